// File: rtl/branch_resolver.sv
// branch_resolver
//   Resolves conditional branches sitting in the D stage. It picks the
//   compare flag that matches the branch type, stalls F/D until the
//   forwarded operands are final, and for a taken branch raises a
//   registered redirect request to F. The request is held until F accepts
//   it. Two wrap-around counters record how many branches resolved taken
//   and how many resolved not taken, for debug readout.
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   ibr_valid       D stage holds a conditional branch
//   ibr_type        0 beq, 1 bne, 2 bltz, 3 blez, 4 bgtz, 5 bgez, 6/7 reserved
//   icmp            compare vector, bit n is the flag for branch type n
//   iops_ready      forwarded operands feeding icmp are final
//   itarget         branch target computed in D
//   ifetch_ready    F accepts the redirect this cycle
//   ostall          freeze F/D (combinational)
//   oredirect_valid redirect request pending (registered)
//   oredirect_pc    redirect target (registered)
//   otaken_cnt      resolved-taken count
//   onottaken_cnt   resolved-not-taken count
module branch_resolver #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ibr_valid,
    input  logic [2:0]        ibr_type,
    input  logic [7:0]        icmp,
    input  logic              iops_ready,
    input  logic [ADDR_W-1:0] itarget,
    input  logic              ifetch_ready,
    output logic              ostall,
    output logic              oredirect_valid,
    output logic [ADDR_W-1:0] oredirect_pc,
    output logic [CNT_W-1:0]  otaken_cnt,
    output logic [CNT_W-1:0]  onottaken_cnt
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_OPS = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // The compare vector is laid out so that flag n belongs to branch type n.
    // Reserved types never branch; icmp[7:6] is therefore never selected.
    function automatic logic branch_taken(input logic [2:0] btype,
                                          input logic [7:0] cmp);
        logic t;
        t = 1'b0;
        if (btype <= 3'd5) begin
            t = cmp[btype];
        end
        return t;
    endfunction

    logic [1:0] state;
    logic [1:0] next_state;
    logic       resolve_en;
    logic       taken;

    assign taken = branch_taken(ibr_type, icmp);

    always_comb begin
        next_state = state;
        resolve_en = 1'b0;
        ostall     = 1'b0;
        case (state)
            S_IDLE: begin
                if (ibr_valid) begin
                    if (iops_ready) begin
                        resolve_en = 1'b1;
                    end else begin
                        ostall     = 1'b1;
                        next_state = S_WAIT_OPS;
                    end
                end
            end
            S_WAIT_OPS: begin
                ostall = ~iops_ready;
                if (!ibr_valid) begin
                    // Branch flushed while waiting: forget it, nothing counted.
                    next_state = S_IDLE;
                end else if (iops_ready) begin
                    resolve_en = 1'b1;
                    next_state = S_IDLE;
                end
            end
            S_REDIRECT: begin
                // A following branch is frozen in D and only resolved once
                // the redirect has been accepted and we are back in IDLE.
                ostall = ibr_valid;
                if (ifetch_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
        if (resolve_en && taken) begin
            next_state = S_REDIRECT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            oredirect_valid <= 1'b0;
            oredirect_pc    <= '0;
            otaken_cnt      <= '0;
            onottaken_cnt   <= '0;
        end else begin
            state <= next_state;
            if (resolve_en) begin
                if (taken) begin
                    oredirect_valid <= 1'b1;
                    oredirect_pc    <= itarget;
                    otaken_cnt      <= otaken_cnt + CNT_ONE;
                end else begin
                    onottaken_cnt   <= onottaken_cnt + CNT_ONE;
                end
            end
            // Resolution cannot happen in REDIRECT, so set and clear never collide.
            if (state == S_REDIRECT && ifetch_ready) begin
                oredirect_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Testbench for branch_resolver: directed scenarios plus randomized traffic
// against a behavioural model; redirects are checked by a scoreboard monitor.
module tb_branch_resolver;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ibr_valid = 1'b0;
    logic [2:0]        ibr_type = '0;
    logic [7:0]        icmp = '0;
    logic              iops_ready = 1'b0;
    logic [ADDR_W-1:0] itarget = '0;
    logic              ifetch_ready = 1'b0;
    logic              ostall;
    logic              oredirect_valid;
    logic [ADDR_W-1:0] oredirect_pc;
    logic [CNT_W-1:0]  otaken_cnt;
    logic [CNT_W-1:0]  onottaken_cnt;

    branch_resolver #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .ibr_valid(ibr_valid), .ibr_type(ibr_type),
        .icmp(icmp), .iops_ready(iops_ready), .itarget(itarget),
        .ifetch_ready(ifetch_ready), .ostall(ostall),
        .oredirect_valid(oredirect_valid), .oredirect_pc(oredirect_pc),
        .otaken_cnt(otaken_cnt), .onottaken_cnt(onottaken_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected redirect transactions: target plus taken count at acceptance.
    typedef struct { logic [ADDR_W-1:0] pc; logic [CNT_W-1:0] tk; } redir_t;
    redir_t exp_q[$];

    // Behavioural model: is a redirect outstanding, is a branch waiting for
    // operands, last redirect target, and the two counts.
    bit               m_busy, m_wait;
    logic [ADDR_W-1:0] m_pc;
    logic [CNT_W-1:0]  m_tk, m_ntk;

    function automatic bit m_taken(input int t, input logic [7:0] c);
        if (t >= 6) return 1'b0;
        return ((c >> t) & 8'h01) != 8'h00;
    endfunction

    function automatic void m_reset();
        m_busy = 0; m_wait = 0; m_pc = '0; m_tk = '0; m_ntk = '0;
        exp_q.delete();
    endfunction

    // One clock: drive, check away from the edge, advance the model at the edge.
    task automatic step(input bit v, input int t, input logic [7:0] c, input bit r,
                        input logic [ADDR_W-1:0] tgt, input bit fr, input bit full = 1);
        bit exp_stall;
        redir_t e;
        ibr_valid = v; ibr_type = t[2:0]; icmp = c; iops_ready = r;
        itarget = tgt; ifetch_ready = fr;
        @(negedge clk);
        if (m_busy)      exp_stall = v;
        else if (m_wait) exp_stall = !r;
        else             exp_stall = v && !r;
        chk("ostall", ostall, exp_stall);
        chk("redirect_valid", oredirect_valid, m_busy);
        if (full) begin
            chk("redirect_pc", oredirect_pc, m_pc);
            chk("taken_cnt", otaken_cnt, m_tk);
            chk("nottaken_cnt", onottaken_cnt, m_ntk);
        end
        @(posedge clk);
        if (m_busy) begin
            if (fr) m_busy = 0;
        end else if (m_wait || v) begin
            if (!v) begin
                m_wait = 0;
            end else if (r) begin
                m_wait = 0;
                if (m_taken(t, c)) begin
                    m_tk++; m_pc = tgt; m_busy = 1;
                    e.pc = tgt; e.tk = m_tk;
                    exp_q.push_back(e);
                end else begin
                    m_ntk++;
                end
            end else begin
                m_wait = 1;
            end
        end
        #1;
    endtask

    // Monitor: every accepted redirect must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && oredirect_valid && ifetch_ready) begin
            redir_t e;
            if (exp_q.size() == 0) begin
                chk("unexpected_redirect", {32'h0, oredirect_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("mon_pc", oredirect_pc, e.pc);
                chk("mon_taken_cnt", otaken_cnt, e.tk);
            end
        end
    end

    logic [2:0]        r_type;
    logic [ADDR_W-1:0] r_tgt;

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", oredirect_valid, 1'b0);
        chk("reset_pc", oredirect_pc, '0);
        chk("reset_tk", otaken_cnt, '0);
        chk("reset_ntk", onottaken_cnt, '0);
        chk("reset_stall", ostall, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // beq taken with operands ready and F ready
        step(1, 0, 8'h01, 1, 32'h0000_3040, 1);
        step(0, 0, 8'h00, 0, 32'h0, 1);
        chk("beq_tk", otaken_cnt, 16'd1);
        step(0, 0, 8'h00, 0, 32'h0, 1);

        // bgtz not taken
        step(1, 4, 8'h06, 1, 32'h0000_5000, 1);
        step(0, 0, 8'h00, 0, 32'h0, 1);
        chk("bgtz_ntk", onottaken_cnt, 16'd1);

        // operand hazard on bne: three stall cycles, then resolve
        for (int i = 0; i < 3; i++) step(1, 1, 8'h00, 0, 32'h0000_7100, 1);
        step(1, 1, 8'h02, 1, 32'h0000_7100, 1);
        step(0, 0, 8'h00, 0, 32'h0, 1);
        step(0, 0, 8'h00, 0, 32'h0, 1);

        // flush while waiting for operands
        step(1, 0, 8'h01, 0, 32'h0000_9000, 1);
        step(0, 0, 8'h01, 1, 32'h0000_9000, 1);
        step(0, 0, 8'h00, 0, 32'h0, 1);

        // fetch back-pressure on taken bgez; a branch arrives meanwhile
        step(1, 5, 8'h20, 1, 32'h0000_A0A0, 0);
        step(0, 0, 8'h00, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 8'h01, 1, 32'h0000_BBBB, 0);
        step(1, 0, 8'h01, 1, 32'h0000_BBBB, 1);
        step(1, 0, 8'h01, 1, 32'h0000_BBBB, 1);
        step(0, 0, 8'h00, 0, 32'h0, 1);
        step(0, 0, 8'h00, 0, 32'h0, 1);

        // reserved type with every flag set
        step(1, 7, 8'hFF, 1, 32'h0000_C000, 1);
        step(1, 6, 8'hFF, 1, 32'h0000_C000, 1);
        step(0, 0, 8'h00, 0, 32'h0, 1);

        // randomized traffic; type/target held while D is frozen
        r_type = 3'd0; r_tgt = '0;
        for (int i = 0; i < 3000; i++) begin
            bit v, r, fr, hold;
            hold = m_wait || (m_busy && ibr_valid);
            if (!hold) begin
                r_type = 3'($urandom_range(0, 7));
                r_tgt  = $urandom;
            end
            v  = hold ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) != 0);
            r  = $urandom_range(0, 2) != 0;
            fr = $urandom_range(0, 2) != 0;
            step(v, int'(r_type), {2'b00, 6'($urandom)}, r, r_tgt, fr);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 32'h0, 1);

        // async reset while a redirect is held
        step(1, 2, 8'h04, 1, 32'h0000_D00D, 0);
        ibr_valid = 1'b0; iops_ready = 1'b0; ifetch_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", oredirect_valid, 1'b0);
        chk("arst_tk", otaken_cnt, '0);
        chk("arst_ntk", onottaken_cnt, '0);
        chk("arst_stall", ostall, 1'b0);
        m_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0, 32'h0, 1);

        // counter wrap: 65535 not-taken branches, then one more
        for (int i = 0; i < 65535; i++) step(1, 3, 8'h00, 1, 32'h0, 1, 0);
        step(0, 0, 8'h00, 0, 32'h0, 1);
        chk("ntk_max", onottaken_cnt, 16'hFFFF);
        step(1, 4, 8'h00, 1, 32'h0, 1);
        step(0, 0, 8'h00, 0, 32'h0, 1);
        chk("ntk_wrap", onottaken_cnt, 16'h0000);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
